mem_port_arbiter: RTL
=====================

# mem_port_arbiter

Two-master arbiter and sequencer for the single-port 9-bit program/data memory shared by two processor cores, or by a core and a loader. Each master issues one word transaction at a time with a req/ack handshake. The block serialises the transactions onto the memory port (address, write data, write enable, enable), waits out the memory read latency, and returns read data to the winning master. It sits between the masters' ADDR/Dout/W outputs and the synchronous RAM.

## Interface
- `DW`, 9: data width.
- `AW`, 9: address width.
- `RD_LAT`, 1: memory read latency in cycles, from the enable cycle to valid data; legal range 1..4.

Ports:
- `clk`  in  1  clock; all state updates on rising edge.
- `rst`  in  1  reset; synchronous and active-high.
- `req0`, `req1`  in  1  transaction request, master 0 / master 1.
- `addr0`, `addr1`  in  AW  request address.
- `wdata0`, `wdata1`  in  DW  write data.
- `we0`, `we1`  in  1  1 = write, 0 = read.
- `ack0`, `ack1`  out  1  one-cycle completion pulse.
- `rdata0`, `rdata1`  out  DW  read data, valid when the matching ack is high; held until that master's next read completes.
- `gnt`  out  2  one-hot owner of the memory port; 0 when idle.
- `mem_en`  out  1  memory access strobe.
- `mem_we`  out  1  memory write enable.
- `mem_addr`  out  AW  memory address.
- `mem_wdata`  out  DW  memory write data.
- `mem_rdata`  in  DW  memory read data, valid `RD_LAT` cycles after `mem_en`.
- `busy`  out  1  state is not IDLE.

## Operation
- FSM states: IDLE, ISSUE, WAIT, RESP.
- **IDLE:** if any `req` is high, select a winner, register the winner's addr/wdata/we and set `gnt`, then go to ISSUE. Otherwise stay in IDLE.
- **ISSUE:** one cycle. `mem_en`=1, `mem_we`=the latched we, and `mem_addr`/`mem_wdata` driven from the latched values. A write goes to RESP; a read goes to WAIT with the counter loaded to `RD_LAT`.
- **WAIT:** lasts `RD_LAT` cycles; the counter decrements each cycle. When the counter reaches 1, `mem_rdata` is captured into the winner's `rdata` at the end of that cycle, and the FSM goes to RESP.
- **RESP:** the winner's `ack`=1 for this cycle only. `gnt` clears at the end of the cycle and the FSM returns to IDLE.
- **Master obligations:**
  - Hold req/addr/wdata/we stable from assertion until ack.
  - Deassert req in the cycle after ack, or keep it high to start a new transaction.
- **Illegal request withdrawal:** if req drops before ack, the transaction still completes and ack still pulses.
- **Reset:** a write returns no read data; the `rdata` registers are unchanged by writes. The non-winning request stays pending and is not affected.
- **Arbitration:** winner selection is either round-robin or fixed priority; see Configuration.

## Timing
- Reset values:
  - state = IDLE
  - `gnt` = 0
  - `ack0` = `ack1` = 0
  - `mem_en` = `mem_we` = 0
  - `mem_addr` = `mem_wdata` = 0
  - `rdata0` = `rdata1` = 0
  - `busy` = 0
  - last-grant = master 1
- All outputs are registered or decoded from state only; there is no combinational path from any `req` to any output.
- **Write latency:** req sampled in cycle 0 → `mem_en` in cycle 1 → ack in cycle 2. Throughput is one write per 3 cycles, because cycle 3 is IDLE.
- **Read latency:** req sampled in cycle 0 → `mem_en` in cycle 1 → WAIT in cycles 2..1+`RD_LAT` → ack in cycle 2+`RD_LAT` (cycle 3 for `RD_LAT`=1).
- **Simultaneous requests:** exactly one winner; the loser is granted in the next IDLE cycle, with no requests lost.
- **Reset mid-transaction:** the FSM returns to IDLE on the next edge and no ack is issued. A write whose ISSUE cycle coincides with `rst` high is still performed by the RAM.

## Configuration
- `ARB_RR_EN` defined: round-robin. On simultaneous requests, grant the master not granted last; update last-grant on each grant. The first contention after reset goes to master 0.
- `ARB_RR_EN` undefined: fixed priority, master 0 always wins. Master 1 can starve. The last-grant register is not built.

## Test plan
- **Write then read, master 0 (`RD_LAT`=1):**
  - Stimulus: write 9'h1A5 to addr 9'h010, then read addr 9'h010.
  - Write: `mem_en`/`mem_we` high in cycle 1, `ack0` in cycle 2.
  - Read: `ack0` in cycle 3 with `rdata0`=9'h1A5; `rdata1` stays 0.
- **Contention (`ARB_RR_EN` defined):**
  - Stimulus: `req0` and `req1` both held continuously, each re-requesting after its ack.
  - Required: `gnt` sequence 01,10,01,10, with acks alternating `ack0`,`ack1`.
- **Contention (`ARB_RR_EN` undefined):**
  - Stimulus: same as above.
  - Required: `ack0` on every transaction and no `ack1` while `req0` is held.
- **Latency sweep:**
  - Stimulus: `RD_LAT`=3, memory preloaded with addr 9'h0FF = 9'h033; master 1 reads 9'h0FF.
  - Required: `mem_en` in cycle 1, `ack1` in cycle 5, `rdata1`=9'h033; `busy` high in cycles 1–5.
- **Reset mid-read:**
  - Stimulus: assert `rst` during WAIT.
  - Required: no ack; all outputs at reset values next cycle. A pending `req0` after reset release gets `mem_en` 1 cycle later.
- **Early req drop:**
  - Stimulus: master 0 starts a write, then drops `req0` during ISSUE.
  - Required: the write is still performed, `ack0` pulses in cycle 2, and the FSM returns to IDLE.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: two-master req/ack arbiter and sequencer for a single-port
// synchronous RAM. One word transaction at a time is serialised onto the
// memory port. The block waits out the RAM read latency and returns read data
// to the master that won arbitration.
//
// Build option:
//   ARB_RR_EN  defined   -> round-robin between the masters on contention
//              undefined -> fixed priority, master 0 always wins
//
// All outputs are registered or decoded from state. No req reaches an output
// combinationally.
module mem_port_arbiter #(
    parameter int DW     = 9,
    parameter int AW     = 9,
    parameter int RD_LAT = 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req0,
    input  logic          req1,
    input  logic [AW-1:0] addr0,
    input  logic [AW-1:0] addr1,
    input  logic [DW-1:0] wdata0,
    input  logic [DW-1:0] wdata1,
    input  logic          we0,
    input  logic          we1,
    output logic          ack0,
    output logic          ack1,
    output logic [DW-1:0] rdata0,
    output logic [DW-1:0] rdata1,
    output logic [1:0]    gnt,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    output logic          busy
);

    // state  | meaning
    // IDLE   | port free, arbitrating pending requests
    // ISSUE  | memory strobe driven from latched request
    // WAIT   | counting down read latency, capture on last cycle
    // RESP   | ack pulse to the owner, grant released
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    localparam int CW = $clog2(RD_LAT + 1);

    state_t          state_q, state_d;
    logic [1:0]      gnt_q, gnt_d;
    logic [AW-1:0]   addr_q, addr_d;
    logic [DW-1:0]   wdata_q, wdata_d;
    logic            we_q, we_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [DW-1:0]   rdata0_q, rdata0_d;
    logic [DW-1:0]   rdata1_q, rdata1_d;

    logic            any_req;
    logic            win1;

`ifdef ARB_RR_EN
    // last_q = 1 means master 1 received the most recent grant
    logic            last_q, last_d;
`endif

    // Winner selection among the current requests
    always_comb begin
        any_req = req0 | req1;
`ifdef ARB_RR_EN
        if (req0 && req1) begin
            win1 = ~last_q;
        end else begin
            win1 = req1;
        end
`else
        win1 = req1 & ~req0;
`endif
    end

    // Next-state and datapath update for the sequencer
    always_comb begin
        state_d  = state_q;
        gnt_d    = gnt_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        we_d     = we_q;
        cnt_d    = cnt_q;
        rdata0_d = rdata0_q;
        rdata1_d = rdata1_q;
`ifdef ARB_RR_EN
        last_d   = last_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (any_req) begin
                    if (win1) begin
                        gnt_d   = 2'b10;
                        addr_d  = addr1;
                        wdata_d = wdata1;
                        we_d    = we1;
                    end else begin
                        gnt_d   = 2'b01;
                        addr_d  = addr0;
                        wdata_d = wdata0;
                        we_d    = we0;
                    end
`ifdef ARB_RR_EN
                    last_d  = win1;
`endif
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (we_q) begin
                    state_d = S_RESP;
                end else begin
                    cnt_d   = CW'(RD_LAT);
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (cnt_q == CW'(1)) begin
                    if (gnt_q[1]) begin
                        rdata1_d = mem_rdata;
                    end else begin
                        rdata0_d = mem_rdata;
                    end
                    state_d = S_RESP;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            S_RESP: begin
                gnt_d   = 2'b00;
                state_d = S_IDLE;
            end
            default: begin
                gnt_d   = 2'b00;
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            gnt_q    <= 2'b00;
            addr_q   <= '0;
            wdata_q  <= '0;
            we_q     <= 1'b0;
            cnt_q    <= '0;
            rdata0_q <= '0;
            rdata1_q <= '0;
        end else begin
            state_q  <= state_d;
            gnt_q    <= gnt_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            we_q     <= we_d;
            cnt_q    <= cnt_d;
            rdata0_q <= rdata0_d;
            rdata1_q <= rdata1_d;
        end
    end

`ifdef ARB_RR_EN
    // Last-grant register; reset to master 1 so the first contention goes to master 0
    always_ff @(posedge clk) begin
        if (rst) begin
            last_q <= 1'b1;
        end else begin
            last_q <= last_d;
        end
    end
`endif

    assign gnt       = gnt_q;
    assign busy      = (state_q != S_IDLE);
    assign mem_en    = (state_q == S_ISSUE);
    assign mem_we    = (state_q == S_ISSUE) & we_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign ack0      = (state_q == S_RESP) & gnt_q[0];
    assign ack1      = (state_q == S_RESP) & gnt_q[1];
    assign rdata0    = rdata0_q;
    assign rdata1    = rdata1_q;

endmodule
